// File: rtl/k005297_dmadregunldctrl.sv
// K005297 DMA data register unload control: DMA words to bubble write bits.
// Define K005297_UNLD_MSBFIRST_EN to shift bytes out MSB-first.
module k005297_dmadregunldctrl #(
  parameter int LEN_W = 10
) (
  input  logic             i_MCLK,
  input  logic             i_SYS_RST,
  input  logic             i_CLK2M_PCEN_n,
  input  logic             i_4BEN_n,
  input  logic             i_WR_START,
  input  logic [LEN_W-1:0] i_PAGE_LEN,
  input  logic [15:0]      i_DMA_WORD,
  input  logic             i_DMA_WORD_VALID,
  output logic             o_DMA_WORD_REQ,
  input  logic             i_BIT_STROBE,
  output logic [3:0]       o_BDO,
  output logic             o_NEWBYTE,
  output logic             o_DMADREG_BDHI_UNLD,
  output logic             o_DMADREG_BDLO_UNLD,
  output logic             o_BUSY,
  output logic             o_DONE,
  output logic             o_UNDERRUN
);

  typedef enum logic [1:0] {IDLE, FETCH, HI, LO} state_t;

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic [15:0]      hold;
  logic [7:0]       sr;
  logic [1:0]       scnt;
  logic             wp;
  logic             first;
  logic             req;
  logic             nb;
  logic             done;
  logic             ur;

  logic             en;
  logic             take;
  logic             have;
  logic             byte_end;
  logic [15:0]      nword;
  logic [LEN_W-1:0] cnt_m1;
  logic [7:0]       sr_nxt;
  logic [3:0]       bits;

  assign en       = ~i_CLK2M_PCEN_n;
  assign take     = req & i_DMA_WORD_VALID;
  assign have     = wp | take;
  // A word arriving this cycle bypasses the hold register.
  assign nword    = wp ? hold : i_DMA_WORD;
  assign byte_end = i_BIT_STROBE &
                    (scnt == (i_4BEN_n ? 2'd3 : 2'd1));
  assign cnt_m1   = cnt - LEN_W'(1);

`ifdef K005297_UNLD_MSBFIRST_EN
  assign sr_nxt = i_4BEN_n ? {sr[5:0], 2'b00}
                           : {sr[3:0], 4'h0};
  assign bits   = i_4BEN_n ? {2'b00, sr[7:6]}
                           : sr[7:4];
`else
  assign sr_nxt = i_4BEN_n ? {2'b00, sr[7:2]}
                           : {4'h0, sr[7:4]};
  assign bits   = i_4BEN_n ? {2'b00, sr[1:0]}
                           : sr[3:0];
`endif

  assign o_BDO = (state == HI || state == LO) ? bits : 4'h0;
  assign o_DMA_WORD_REQ      = req;
  assign o_NEWBYTE           = nb;
  assign o_DONE              = done;
  assign o_UNDERRUN          = ur;
  assign o_BUSY              = (state != IDLE);
  assign o_DMADREG_BDHI_UNLD = (state == HI);
  assign o_DMADREG_BDLO_UNLD = (state == LO);

  always_ff @(posedge i_MCLK) begin
    if (i_SYS_RST) begin
      state <= IDLE;
      cnt   <= '0;
      hold  <= '0;
      sr    <= '0;
      scnt  <= '0;
      wp    <= 1'b0;
      first <= 1'b0;
      req   <= 1'b0;
      nb    <= 1'b0;
      done  <= 1'b0;
      ur    <= 1'b0;
    end else if (en) begin
      nb   <= 1'b0;
      done <= 1'b0;
      if (take) begin
        hold <= i_DMA_WORD;
        wp   <= 1'b1;
        req  <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (i_WR_START) begin
            cnt   <= i_PAGE_LEN;
            ur    <= 1'b0;
            req   <= 1'b1;
            wp    <= 1'b0;
            first <= 1'b1;
            state <= FETCH;
          end
        end
        FETCH: begin
          if (i_BIT_STROBE && !first)
            ur <= 1'b1;
          if (have) begin
            sr    <= nword[15:8];
            scnt  <= '0;
            nb    <= 1'b1;
            cnt   <= cnt_m1;
            first <= 1'b0;
            state <= HI;
          end
        end
        HI: begin
          if (i_BIT_STROBE) begin
            sr   <= sr_nxt;
            scnt <= scnt + 2'd1;
            if (byte_end) begin
              if (cnt == '0) begin
                done  <= 1'b1;
                req   <= 1'b0;
                wp    <= 1'b0;
                state <= IDLE;
              end else begin
                sr    <= hold[7:0];
                scnt  <= '0;
                nb    <= 1'b1;
                cnt   <= cnt_m1;
                wp    <= 1'b0;
                state <= LO;
                if (cnt_m1 != '0)
                  req <= 1'b1;
              end
            end
          end
        end
        LO: begin
          if (i_BIT_STROBE) begin
            sr   <= sr_nxt;
            scnt <= scnt + 2'd1;
            if (byte_end) begin
              if (cnt == '0) begin
                done  <= 1'b1;
                req   <= 1'b0;
                wp    <= 1'b0;
                state <= IDLE;
              end else if (have) begin
                sr    <= nword[15:8];
                scnt  <= '0;
                nb    <= 1'b1;
                cnt   <= cnt_m1;
                state <= HI;
              end else begin
                state <= FETCH;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_k005297_dmadregunldctrl.sv
// Directed bench for k005297_dmadregunldctrl: page vectors plus
// hand sequences for underrun, reset abort and clock-enable hold.
module tb_k005297_dmadregunldctrl;
  localparam int LEN_W = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             pcen_n;
  logic             m2n;
  logic             start;
  logic [LEN_W-1:0] plen;
  logic [15:0]      word;
  logic             valid;
  logic             strobe;
  logic             req;
  logic [3:0]       bdo;
  logic             nb;
  logic             hi;
  logic             lo;
  logic             busy;
  logic             done;
  logic             ur;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  k005297_dmadregunldctrl #(.LEN_W(LEN_W)) dut (
    .i_MCLK              (clk),
    .i_SYS_RST           (rst),
    .i_CLK2M_PCEN_n      (pcen_n),
    .i_4BEN_n            (m2n),
    .i_WR_START          (start),
    .i_PAGE_LEN          (plen),
    .i_DMA_WORD          (word),
    .i_DMA_WORD_VALID    (valid),
    .o_DMA_WORD_REQ      (req),
    .i_BIT_STROBE        (strobe),
    .o_BDO               (bdo),
    .o_NEWBYTE           (nb),
    .o_DMADREG_BDHI_UNLD (hi),
    .o_DMADREG_BDLO_UNLD (lo),
    .o_BUSY              (busy),
    .o_DONE              (done),
    .o_UNDERRUN          (ur)
  );

  typedef struct {
    logic        m2;
    int          len;
    logic [15:0] w0;
    logic [15:0] w1;
    int          nbytes;
    logic [7:0]  b0, b1, b2, b3;
    int          nreq;
    int          dly;
  } vec_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] slice(input logic [7:0] b,
                                       input logic m2,
                                       input int k);
    logic [7:0] s;
`ifdef K005297_UNLD_MSBFIRST_EN
    s = m2 ? (b >> (6 - 2*k)) & 8'h03 : (b >> (4 - 4*k)) & 8'h0f;
`else
    s = m2 ? (b >> (2*k)) & 8'h03 : (b >> (4*k)) & 8'h0f;
`endif
    return s[3:0];
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0] bytes [4];
    int sb, nbc, nrq, age, wi, gap, per;
    bit fin;
    logic prq;
    bytes = '{v.b0, v.b1, v.b2, v.b3};
    per = v.m2 ? 4 : 2;
    m2n = v.m2;
    plen = LEN_W'(v.len);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk({tag, " busy"}, busy, 1);
    sb = 0; nbc = 0; nrq = 0; age = 0;
    wi = 0; gap = 0; fin = 0; prq = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      valid = 1'b0;
      strobe = 1'b0;
      if (req && !prq) nrq++;
      age = (req && prq) ? age + 1 : 0;
      prq = req;
      if (nb) nbc++;
      if (done) begin
        fin = 1;
      end else begin
        if (req && age == v.dly && wi < 2) begin
          valid = 1'b1;
          word = (wi == 0) ? v.w0 : v.w1;
          wi++;
        end
        if (hi || lo) begin
          if (sb < v.nbytes * per)
            chk($sformatf("%s bdo%0d", tag, sb), bdo,
                slice(bytes[sb / per], v.m2, sb % per));
          strobe = 1'b1;
          sb++;
        end else if (nbc > 0) begin
          gap++;
        end
        tick;
      end
    end
    valid = 1'b0;
    strobe = 1'b0;
    chk({tag, " done"}, fin, 1);
    chk({tag, " strobes"}, sb, v.nbytes * per);
    chk({tag, " newbytes"}, nbc, v.nbytes);
    chk({tag, " reqs"}, nrq, v.nreq);
    chk({tag, " fetch gap"}, gap, 0);
    chk({tag, " underrun"}, ur, 0);
    chk({tag, " idle"}, busy, 0);
  endtask

  vec_t vt [4];

  initial begin
    vt[0] = '{1'b1, 2, 16'hA55A, 16'h0000, 2,
              8'hA5, 8'h5A, 8'h00, 8'h00, 1, 2};
    vt[1] = '{1'b0, 4, 16'h1234, 16'h5678, 4,
              8'h12, 8'h34, 8'h56, 8'h78, 2, 1};
    vt[2] = '{1'b1, 3, 16'h1122, 16'h3344, 3,
              8'h11, 8'h22, 8'h33, 8'h00, 2, 0};
    vt[3] = '{1'b0, 1, 16'hBEEF, 16'h0000, 1,
              8'hBE, 8'h00, 8'h00, 8'h00, 1, 0};

    rst = 1'b1; pcen_n = 1'b0; m2n = 1'b1; start = 1'b0;
    plen = '0; word = '0; valid = 1'b0; strobe = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    chk("reset outs", {req, bdo, nb, hi, lo, busy, done, ur}, 0);

    for (int i = 0; i < 4; i++)
      run_vec(vt[i], $sformatf("vec%0d", i));

    // underrun: second word withheld, two strobes while stalled
    m2n = 1'b0; plen = 4; start = 1'b1;
    tick;
    start = 1'b0;
    valid = 1'b1; word = 16'h1234;
    tick;
    valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ur bdo%0d", k), bdo,
          slice(k < 2 ? 8'h12 : 8'h34, 1'b0, k % 2));
      strobe = 1'b1;
      tick;
      strobe = 1'b0;
    end
    chk("ur stall flags", {hi, lo, busy}, 3'b001);
    chk("ur req", req, 1);
    chk("ur pre", ur, 0);
    for (int k = 0; k < 2; k++) begin
      chk("ur stall bdo", bdo, 0);
      strobe = 1'b1;
      tick;
      strobe = 1'b0;
    end
    chk("ur set", ur, 1);
    valid = 1'b1; word = 16'h5678;
    tick;
    valid = 1'b0;
    chk("ur late nb", {nb, hi}, 2'b11);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ur late bdo%0d", k), bdo,
          slice(k < 2 ? 8'h56 : 8'h78, 1'b0, k % 2));
      strobe = 1'b1;
      tick;
      strobe = 1'b0;
    end
    chk("ur done", done, 1);
    chk("ur sticky", ur, 1);
    plen = 2; start = 1'b1;
    tick;
    start = 1'b0;
    chk("ur cleared", ur, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort fetch", {req, busy}, 0);

    // reset mid-page after three strobes
    m2n = 1'b1; plen = 8; start = 1'b1;
    tick;
    start = 1'b0;
    valid = 1'b1; word = 16'h0F0F;
    tick;
    valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst bdo%0d", k), bdo, slice(8'h0F, 1'b1, k));
      strobe = 1'b1;
      tick;
      strobe = 1'b0;
    end
    rst = 1'b1; strobe = 1'b1;
    tick;
    rst = 1'b0; strobe = 1'b0;
    chk("rst outs", {req, bdo, nb, hi, lo, busy, done, ur}, 0);
    tick;
    chk("rst no done", done, 0);
    run_vec(vt[0], "restart");

    // enable held high with strobe, valid and start active
    m2n = 1'b1; plen = 2; start = 1'b1;
    tick;
    start = 1'b0;
    valid = 1'b1; word = 16'hA55A;
    tick;
    valid = 1'b0;
    pcen_n = 1'b1; strobe = 1'b1; valid = 1'b1;
    word = 16'hFFFF; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk($sformatf("hold%0d", k), {bdo, nb, hi, req, busy},
          {slice(8'hA5, 1'b1, 0), 4'b1101});
    end
    pcen_n = 1'b0; strobe = 1'b0; valid = 1'b0; start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("hold bdo%0d", k), bdo,
          slice(k < 4 ? 8'hA5 : 8'h5A, 1'b1, k % 4));
      strobe = 1'b1;
      start = (k == 2);
      tick;
      strobe = 1'b0;
      start = 1'b0;
    end
    chk("hold done", {done, busy}, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
